// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table and
// the all-dark anode/segment patterns.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex nibble
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Index of the most significant nonzero nibble; 0 when the word is zero
    function automatic logic [1:0] msd_index(input logic [15:0] word);
        logic [1:0] idx;
        if (word[15:12] != 4'h0) begin
            idx = 2'd3;
        end else if (word[11:8] != 4'h0) begin
            idx = 2'd2;
        end else if (word[7:4] != 4'h0) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_display_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
import seg7_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_display_scanner.sv
// Four-digit multiplexed common-anode hex display scanner with per-frame input
// snapshot. Optional leading-zero blanking: define SEG7_BLANK_LEADING_ZEROS_EN.
import seg7_pkg::*;

module seg7_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        frame_done
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic [1:0]       digit_r;
    logic [15:0]      shadow_r;
    logic [3:0]       anodes_r;
    logic [6:0]       segments_r;
    logic             frame_done_r;

    logic             last_s;
    logic             wrap_s;
    logic             blank_s;
    logic [3:0]       nibble_s;
    logic [6:0]       dec_seg_s;
    logic [3:0]       an_next_s;
    logic [6:0]       seg_next_s;

    assign last_s   = (div_cnt_r == DIV_LAST);
    assign wrap_s   = last_s && (digit_r == 2'd3);
    assign nibble_s = shadow_r[4*digit_r +: 4];

    hex_to_seg7 u_dec (
        .nibble   (nibble_s),
        .segments (dec_seg_s)
    );

    // Decide whether the current digit is suppressed as a leading zero
    always_comb begin
        blank_s = 1'b0;
`ifdef SEG7_BLANK_LEADING_ZEROS_EN
        if (digit_r > msd_index(shadow_r)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
`endif
    end

    // Next anode/segment pattern for the digit currently selected
    always_comb begin
        an_next_s  = AN_OFF;
        seg_next_s = SEG_BLANK;
        if (blank_s) begin
            an_next_s  = AN_OFF;
            seg_next_s = SEG_BLANK;
        end else begin
            an_next_s  = ~(4'b0001 << digit_r);
            seg_next_s = dec_seg_s;
        end
    end

    // Refresh divider, digit select, frame snapshot and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_r    <= '0;
            digit_r      <= 2'd0;
            shadow_r     <= 16'h0000;
            anodes_r     <= AN_OFF;
            segments_r   <= SEG_BLANK;
            frame_done_r <= 1'b0;
        end else begin
            if (last_s) begin
                div_cnt_r <= '0;
                digit_r   <= digit_r + 2'd1;
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
                digit_r   <= digit_r;
            end
            // The snapshot only moves at frame wrap so a frame is never torn
            if (wrap_s) begin
                shadow_r <= value;
            end else begin
                shadow_r <= shadow_r;
            end
            frame_done_r <= wrap_s;
            anodes_r     <= an_next_s;
            segments_r   <= seg_next_s;
        end
    end

    assign anodes     = anodes_r;
    assign segments   = segments_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Randomized scoreboard bench for seg7_display_scanner with REFRESH_DIV=4.
module tb_seg7_display_scanner;

    localparam int R     = 4;
    localparam int FRAME = 4 * R;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h1234;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        frame_done;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          k = 0;
    logic [15:0] mshadow = 16'h0000;

    seg7_display_scanner #(.REFRESH_DIV(R)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .anodes     (anodes),
        .segments   (segments),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // What the display must show for digit d of displayed word sh
    function automatic exp_t ref_out(input logic [15:0] sh, input int d);
        exp_t       e;
        logic [3:0] one;
        int         nib;
        int         top;
        one   = 4'b0001;
        nib   = int'((sh >> (4 * d)) & 16'h000F);
        e.an  = ~(one << d);
        e.seg = GLYPH[nib];
        e.fd  = 1'b0;
        top   = 0;
        for (int i = 1; i < 4; i++) begin
            if (((sh >> (4 * i)) & 16'h000F) != 16'h0000) top = i;
        end
`ifdef SEG7_BLANK_LEADING_ZEROS_EN
        if (d > top) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
        end
`endif
        return e;
    endfunction

    // Reference model: time since reset release decides digit and frame
    always @(posedge clock) begin : model
        logic [15:0] v;
        logic        r;
        exp_t        e;
        int          s;
        v = value;
        r = reset;
        #1;
        if (r) begin
            k       = 0;
            mshadow = 16'h0000;
            e.an    = 4'b1111;
            e.seg   = 7'b1111111;
            e.fd    = 1'b0;
        end else begin
            k = k + 1;
            s = k - 1;
            e = ref_out(mshadow, (s / R) % 4);
            e.fd = ((k % FRAME) == 0);
            if (e.fd) mshadow = v;
        end
        exp_q.push_back(e);
    end

    int cyc = 0;
    int last_fd = -1;

    // Monitor: pop expected output and compare, plus scan-shape properties
    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({anodes, segments, frame_done} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         $time, anodes, segments, frame_done, e.an, e.seg, e.fd);
            end
        end
        checks++;
        if ($countones(~anodes) > 1) begin
            errors++;
            $display("FAIL one_anode t=%0t got an=%b want at most one low", $time, anodes);
        end
        if (reset) begin
            cyc     = 0;
            last_fd = -1;
        end else begin
            cyc = cyc + 1;
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != FRAME) begin
                        errors++;
                        $display("FAIL fd_spacing got %0d want %0d", cyc - last_fd, FRAME);
                    end
                end
                last_fd = cyc;
            end
        end
    end

    initial begin
        reset = 1'b1;
        value = 16'h1234;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * FRAME + 2) @(negedge clock);

        // ABCD captured at next wrap, then zeroed mid-frame
        value = 16'hABCD;
        repeat (FRAME - 2) @(negedge clock);
        repeat (6) @(negedge clock);
        value = 16'h0000;
        repeat (2 * FRAME) @(negedge clock);

        // Random values changing at arbitrary points in the frame
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 7) == 0) value = 16'($urandom);
        end

        value = 16'h00F0;
        repeat (2 * FRAME + 3) @(negedge clock);

        // Asynchronous reset at digit 2, div_cnt 1
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        value = 16'($urandom);
        repeat (9) @(negedge clock);
        #1;
        checks++;
        if (anodes !== 4'b1011) begin
            errors++;
            $display("FAIL pre_async_reset got an=%b want 1011", anodes);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({anodes, segments, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%b fd=%b want 1111 1111111 0",
                     anodes, segments, frame_done);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3 * FRAME + 2) @(negedge clock);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
